// File: rtl/async_fifo_pkg.sv
// ============================================================================
// Module : async_fifo_pkg
// Brief  : Shared types and round-robin helper for the async_fifo write arbiter.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package async_fifo_pkg;

    typedef enum logic [0:0] {
        ARB  = 1'b0,
        XFER = 1'b1
    } arb_state_t;

    // First set bit of mask scanning upward from last+1, wrapping at reqs (<= 16).
    function automatic logic [3:0] rr_next(
        input logic [15:0] mask,
        input logic [3:0]  last,
        input int          reqs
    );
        logic [3:0] pick;
        logic       found;
        logic [4:0] idx;
        pick  = 4'd0;
        found = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            idx = {1'b0, last} + 5'(i);
            if (idx >= 5'(reqs)) begin
                idx = idx - 5'(reqs);
            end
            if (!found && (i <= reqs) && mask[idx[3:0]]) begin
                pick  = idx[3:0];
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

`default_nettype wire

// File: rtl/async_fifo_write_arbiter_rr_pick.sv
// ============================================================================
// Module : rr_pick
// Brief  : Combinational round-robin winner selection after the last owner.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module rr_pick
    import async_fifo_pkg::*;
#(
    parameter int REQS = 4
) (
    input  logic [REQS-1:0]         req_mask,
    input  logic [$clog2(REQS)-1:0] last_owner,
    output logic [$clog2(REQS)-1:0] winner,
    output logic                    any
);

    localparam int ID_W = $clog2(REQS);

    logic [3:0] w_pick;

    assign w_pick = rr_next(16'(req_mask), 4'(last_owner), REQS);
    assign winner = w_pick[ID_W-1:0];
    assign any    = |req_mask;

endmodule

`default_nettype wire

// File: rtl/async_fifo_write_arbiter.sv
// ============================================================================
// Module : async_fifo_write_arbiter
// Brief  : Round-robin, burst-bounded sharing of the async_fifo write port.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module async_fifo_write_arbiter
    import async_fifo_pkg::*;
#(
    parameter int BITS      = 32,
    parameter int REQS      = 4,
    parameter int MAX_BURST = 4
) (
    input  logic                    write_clk,
    input  logic                    write_rst_n,
    input  logic [REQS-1:0]         req_valid,
    input  logic [REQS*BITS-1:0]    req_data,
    input  logic [REQS-1:0]         req_last,
    output logic [REQS-1:0]         req_ready,
    output logic                    p_write_en,
    output logic [BITS-1:0]         p_write_data,
    input  logic                    p_write_full,
    output logic [$clog2(REQS)-1:0] grant_id,
    output logic                    busy
);

    localparam int ID_W  = $clog2(REQS);
    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] C_LAST_BEAT = CNT_W'(MAX_BURST - 1);

    arb_state_t       r_state;
    arb_state_t       w_state_next;
    logic [ID_W-1:0]  r_grant_id;
    logic [ID_W-1:0]  r_last_owner;
    logic [CNT_W-1:0] r_beat_cnt;
    logic [ID_W-1:0]  w_pick;
    logic             w_any;
    logic             w_fire;
    logic             w_release;
    logic [BITS-1:0]  w_slice [REQS];

    generate
        for (genvar g = 0; g < REQS; g++) begin : g_slice
            assign w_slice[g] = req_data[g*BITS +: BITS];
        end
    endgenerate

    rr_pick #(
        .REQS (REQS)
    ) u_rr_pick (
        .req_mask   (req_valid),
        .last_owner (r_last_owner),
        .winner     (w_pick),
        .any        (w_any)
    );

    always_ff @(posedge write_clk or negedge write_rst_n) begin
        if (!write_rst_n) begin
            r_state      <= ARB;
            r_grant_id   <= '0;
            r_last_owner <= ID_W'(REQS - 1);
            r_beat_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            if ((r_state == ARB) && w_any) begin
                r_grant_id <= w_pick;
                r_beat_cnt <= '0;
            end
            if (w_fire) begin
                r_beat_cnt <= r_beat_cnt + CNT_W'(1);
            end
            if (w_release) begin
                r_last_owner <= r_grant_id;
            end
        end
    end

    // Outputs stay at zero in ARB; the owner's slice is shown even when stalled.
    always_comb begin
        w_state_next = r_state;
        w_fire       = 1'b0;
        w_release    = 1'b0;
        p_write_en   = 1'b0;
        p_write_data = '0;
        req_ready    = '0;
        case (r_state)
            ARB: begin
                if (w_any) begin
                    w_state_next = XFER;
                end
            end
            XFER: begin
                w_fire                = req_valid[r_grant_id] && !p_write_full;
                p_write_en            = w_fire;
                p_write_data          = w_slice[r_grant_id];
                req_ready[r_grant_id] = w_fire;
                w_release = w_fire && (req_last[r_grant_id] || (r_beat_cnt == C_LAST_BEAT));
                if (w_release) begin
                    w_state_next = ARB;
                end
            end
            default: w_state_next = ARB;
        endcase
    end

    assign busy     = (r_state == XFER);
    assign grant_id = r_grant_id;

endmodule

`default_nettype wire
